// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller definitions: command codes, read-return error flags
// and width helpers for pointer and watchdog sizing.
package ddr3_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic timeout;
  } rdret_err_t;

  localparam int RDRET_DEPTH_DEF = 8;
  localparam int RDRET_PTR_W_DEF = $clog2(RDRET_DEPTH_DEF) + 1;
  localparam int RDRET_WD_MIN_W  = 10;

  // Pointers carry one extra wrap bit above the slot index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int wd_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < RDRET_WD_MIN_W) ? RDRET_WD_MIN_W : w;
  endfunction

endpackage

// File: rtl/ddr3_read_return_if.sv
// Command/return/response bundle between the DDR3 controller FSM, the
// read-return stage (slave) and whoever drives and consumes it (master).
interface ddr3_read_return_if
  import ddr3_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int WORD_WIDTH    = 32,
  parameter int DEPTH         = RDRET_DEPTH_DEF
);
  logic                          cmd_issue;
  logic [ADDRESS_WIDTH-1:0]      cmd_addr;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          rd_data_valid;
  logic                          issue_credit;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ADDRESS_WIDTH-1:0]      resp_addr;
  logic [WORD_WIDTH-1:0]         resp_word;
  logic [DATA_WIDTH-1:0]         resp_line;
  logic [ptr_width(DEPTH)-1:0]   outstanding;
  logic                          err_overflow;
  logic                          err_underflow;
  logic                          err_timeout;

  modport master (
    output cmd_issue, cmd_addr, rd_data, rd_data_valid, resp_ready,
    input  issue_credit, resp_valid, resp_addr, resp_word, resp_line,
           outstanding, err_overflow, err_underflow, err_timeout
  );

  modport slave (
    input  cmd_issue, cmd_addr, rd_data, rd_data_valid, resp_ready,
    output issue_credit, resp_valid, resp_addr, resp_word, resp_line,
           outstanding, err_overflow, err_underflow, err_timeout
  );
endinterface

// File: rtl/ddr3_rdret_buf.sv
// Slot storage for the read-return stage: independent address and line write
// ports, one combinational read port, contents cleared by reset.
module ddr3_rdret_buf #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int DEPTH         = 8,
  localparam int IDX_W        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     addr_we,
  input  logic [IDX_W-1:0]         addr_idx,
  input  logic [ADDRESS_WIDTH-1:0] addr_wdata,
  input  logic                     line_we,
  input  logic [IDX_W-1:0]         line_idx,
  input  logic [DATA_WIDTH-1:0]    line_wdata,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_line
);
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    line_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        line_mem[i] <= '0;
      end
    end else begin
      if (addr_we) addr_mem[addr_idx] <= addr_wdata;
      if (line_we) line_mem[line_idx] <= line_wdata;
    end
  end

  assign rd_addr = addr_mem[rd_idx];
  assign rd_line = line_mem[rd_idx];
endmodule

// File: rtl/ddr3_read_return.sv
// Pairs issued read addresses with returned DDR3 lines in order and hands
// them to the load path; optional watchdog under DDR3_RDRET_TIMEOUT_EN.
module ddr3_read_return
  import ddr3_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int DEPTH          = RDRET_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               rst_n,
  ddr3_read_return_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]         iss_ptr, fill_ptr, rsp_ptr;
  logic [PTR_W-1:0]         pending, ready_cnt;
  logic                     full, issue_ok, fill_ok, consume, resp_valid, tmo_hit;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_line;
  logic [WORD_WIDTH-1:0]    word_sel;
  rdret_err_t               err_q;

  assign pending    = iss_ptr - fill_ptr;
  assign ready_cnt  = fill_ptr - rsp_ptr;
  // Full when indices match but the wrap bits differ.
  assign full       = (iss_ptr[PTR_W-1] != rsp_ptr[PTR_W-1]) &&
                      (iss_ptr[IDX_W-1:0] == rsp_ptr[IDX_W-1:0]);
  assign resp_valid = (ready_cnt != '0);
  assign issue_ok   = bus.cmd_issue && !full;
  assign fill_ok    = bus.rd_data_valid && (pending != '0);
  assign consume    = resp_valid && bus.resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_ptr  <= '0;
      fill_ptr <= '0;
      rsp_ptr  <= '0;
    end else begin
      if (issue_ok) iss_ptr  <= iss_ptr + 1'b1;
      if (fill_ok)  fill_ptr <= fill_ptr + 1'b1;
      if (consume)  rsp_ptr  <= rsp_ptr + 1'b1;
    end
  end

  ddr3_rdret_buf #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_we    (issue_ok),
    .addr_idx   (iss_ptr[IDX_W-1:0]),
    .addr_wdata (bus.cmd_addr),
    .line_we    (fill_ok),
    .line_idx   (fill_ptr[IDX_W-1:0]),
    .line_wdata (bus.rd_data),
    .rd_idx     (rsp_ptr[IDX_W-1:0]),
    .rd_addr    (head_addr),
    .rd_line    (head_line)
  );

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (head_addr[3:2] == 2'(i)) word_sel = head_line[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

`ifdef DDR3_RDRET_TIMEOUT_EN
  localparam int WD_W = wd_width(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             wd_cnt <= '0;
    else if ((pending == '0) || fill_ok)    wd_cnt <= '0;
    else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + 1'b1;
  end

  // Flag on the same edge that the counter lands on the limit.
  assign tmo_hit = (pending != '0) && !fill_ok && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      if (bus.cmd_issue && full)                 err_q.overflow  <= 1'b1;
      if (bus.rd_data_valid && (pending == '0))  err_q.underflow <= 1'b1;
      if (tmo_hit)                               err_q.timeout   <= 1'b1;
    end
  end

  assign bus.issue_credit  = !full;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_addr     = head_addr;
  assign bus.resp_line     = head_line;
  assign bus.resp_word     = word_sel;
  assign bus.outstanding   = iss_ptr - rsp_ptr;
  assign bus.err_overflow  = err_q.overflow;
  assign bus.err_underflow = err_q.underflow;
  assign bus.err_timeout   = err_q.timeout;
endmodule

// File: tb/tb_ddr3_read_return.sv
// Randomized and directed bench for ddr3_read_return against a queue-based
// reference model; honours DDR3_RDRET_TIMEOUT_EN for the watchdog checks.
module tb_ddr3_read_return;
  import ddr3_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int WW    = 32;
  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr3_read_return_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WORD_WIDTH(WW), .DEPTH(DEPTH)) bus ();

  ddr3_read_return #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .WORD_WIDTH    (WW),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [AW-1:0] pend_q[$];
  logic [AW-1:0] rdy_addr_q[$];
  logic [DW-1:0] rdy_line_q[$];
  bit            m_ovf, m_unf, m_tmo;
  int            m_wait;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] word_of(input logic [DW-1:0] line, input logic [AW-1:0] addr);
    logic [DW-1:0] sh;
    sh = line >> (WW * int'(addr[3:2]));
    return sh[WW-1:0];
  endfunction

  task automatic compare_all();
    int occ;
    occ = pend_q.size() + rdy_addr_q.size();
    check("issue_credit", bus.issue_credit, occ < DEPTH);
    check("outstanding", bus.outstanding, occ);
    check("resp_valid", bus.resp_valid, rdy_addr_q.size() != 0);
    check("err_overflow", bus.err_overflow, m_ovf);
    check("err_underflow", bus.err_underflow, m_unf);
    check("err_timeout", bus.err_timeout, m_tmo);
    if (rdy_addr_q.size() != 0) begin
      check("resp_addr", bus.resp_addr, rdy_addr_q[0]);
      check("resp_line", bus.resp_line, rdy_line_q[0]);
      check("resp_word", bus.resp_word, word_of(rdy_line_q[0], rdy_addr_q[0]));
    end
  endtask

  // One clock: the model applies this cycle's events, then outputs are compared.
  task automatic step();
    int  occ;
    bit  fil, con;
    @(posedge clk);
    occ = pend_q.size() + rdy_addr_q.size();
    con = bus.resp_ready && (rdy_addr_q.size() != 0);
    fil = bus.rd_data_valid && (pend_q.size() != 0);
    if (bus.rd_data_valid && pend_q.size() == 0) m_unf = 1'b1;
    if (bus.cmd_issue && occ >= DEPTH) m_ovf = 1'b1;
`ifdef DDR3_RDRET_TIMEOUT_EN
    // Cycles spent with a read outstanding and no data returned.
    if (pend_q.size() == 0 || fil) m_wait = 0;
    else if (m_wait < TMO) begin
      m_wait++;
      if (m_wait == TMO) m_tmo = 1'b1;
    end
`endif
    if (con) begin
      void'(rdy_addr_q.pop_front());
      void'(rdy_line_q.pop_front());
    end
    if (fil) begin
      rdy_addr_q.push_back(pend_q.pop_front());
      rdy_line_q.push_back(bus.rd_data);
    end
    if (bus.cmd_issue && occ < DEPTH) pend_q.push_back(bus.cmd_addr);
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit iss, input logic [AW-1:0] a, input bit vld,
                     input logic [DW-1:0] d, input bit rdy);
    bus.cmd_issue     = iss;
    bus.cmd_addr      = a;
    bus.rd_data_valid = vld;
    bus.rd_data       = d;
    bus.resp_ready    = rdy;
    step();
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.cmd_issue     = 1'b0;
    bus.cmd_addr      = '0;
    bus.rd_data_valid = 1'b0;
    bus.rd_data       = '0;
    bus.resp_ready    = 1'b0;
    pend_q.delete();
    rdy_addr_q.delete();
    rdy_line_q.delete();
    m_ovf = 0; m_unf = 0; m_tmo = 0; m_wait = 0;
    #1;
    check("rst_credit", bus.issue_credit, 1'b1);
    check("rst_valid", bus.resp_valid, 1'b0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_errs", {bus.err_overflow, bus.err_underflow, bus.err_timeout}, 3'b000);
    check("rst_addr", bus.resp_addr, 0);
    check("rst_word", bus.resp_word, 0);
    check("rst_line", bus.resp_line, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] held;
    int            rise;

    bus.cmd_issue = 1'b0; bus.cmd_addr = '0; bus.rd_data_valid = 1'b0;
    bus.rd_data = '0; bus.resp_ready = 1'b0;
    do_reset();

    // Single read: data five cycles after issue, word index 2.
    cyc(1, 32'h0000_1238, 0, '0, 0);
    repeat (4) cyc(0, '0, 0, '0, 0);
    cyc(0, '0, 1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0);
    check("single_word", bus.resp_word, 32'hCCCC_CCCC);
    check("single_outstanding", bus.outstanding, 1);
    cyc(0, '0, 0, '0, 1);
    check("single_drained", bus.outstanding, 0);

    // Fill all slots, overflow with a ninth, then drain in order.
    for (int i = 0; i < DEPTH; i++) cyc(1, $urandom, 0, '0, 0);
    check("full_no_credit", bus.issue_credit, 1'b0);
    cyc(1, 32'hBAD0_0000, 0, '0, 0);
    check("overflow_flag", bus.err_overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1, rand_line(), 1);
    repeat (2) cyc(0, '0, 0, '0, 1);

    // Back-pressure across three returns, then release.
    for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, '0, 0);
    cyc(0, '0, 1, rand_line(), 0);
    held = bus.resp_addr;
    cyc(0, '0, 1, rand_line(), 0);
    cyc(0, '0, 1, rand_line(), 0);
    repeat (2) cyc(0, '0, 0, '0, 0);
    check("bp_held_addr", bus.resp_addr, held);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, '0, 1);
    check("bp_drained", bus.resp_valid, 1'b0);

    // Issue, fill and consume together with four outstanding.
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, '0, 0);
    cyc(0, '0, 1, rand_line(), 0);
    cyc(0, '0, 1, rand_line(), 0);
    cyc(1, $urandom, 1, rand_line(), 1);
    check("simul_outstanding", bus.outstanding, 4);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, rand_line(), 1);
    repeat (3) cyc(0, '0, 0, '0, 1);

    // Return with nothing pending.
    cyc(0, '0, 1, rand_line(), 1);
    check("underflow_flag", bus.err_underflow, 1'b1);

    // Reset with three reads in flight; their late data underflows.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, '0, 0);
    do_reset();
    cyc(0, '0, 1, rand_line(), 1);
    check("late_underflow", bus.err_underflow, 1'b1);

    // Watchdog: one read that never returns.
    do_reset();
    rise = 0;
    cyc(1, 32'h0000_4000, 0, '0, 0);
    for (int k = 1; k <= 40; k++) begin
      cyc(0, '0, 0, '0, 0);
      if (rise == 0 && bus.err_timeout) rise = k;
    end
`ifdef DDR3_RDRET_TIMEOUT_EN
    check("timeout_delay", rise, TMO);
`else
    check("timeout_disabled", rise, 0);
`endif

    // Randomized traffic, mostly honouring credit.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit iss, vld, rdy;
      iss = ($urandom_range(0, 99) < 40) && (bus.issue_credit || $urandom_range(0, 19) == 0);
      vld = (pend_q.size() != 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 49) == 0);
      rdy = $urandom_range(0, 99) < 70;
      a = $urandom;
      cyc(iss, a, vld, rand_line(), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
